// File: rtl/memory_turn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// memory_turn_ctrl_pkg
// Shared game constants and types for the 16-card memory game: board size,
// the card-bank state encoding, and the turn FSM state type.
// -----------------------------------------------------------------------------
package memory_turn_ctrl_pkg;

    localparam int NUM_CARDS = 16;
    localparam int NUM_PAIRS = 8;
    localparam int IDX_W     = 4;
    localparam int SYM_W     = 4;

    // Per-card state as reported by the card bank.
    typedef enum logic [1:0] {
        CARD_DOWN  = 2'd0,
        CARD_UP    = 2'd1,
        CARD_MATCH = 2'd2
    } card_state_e;

    // Turn FSM states.
    typedef enum logic [2:0] {
        T_PICK1,
        T_PICK2,
        T_SHOW,
        T_RESOLVE,
        T_OVER
    } turn_state_e;

endpackage

// File: rtl/memory_turn_ctrl_sec_tick.sv
// -----------------------------------------------------------------------------
// memory_turn_ctrl_sec_tick
// Free-running 0..TICK_CYCLES-1 counter that emits a one-cycle tick in the
// cycle its count sits at TICK_CYCLES-1. clr restarts the count at 0 on the
// next cycle so a freshly reloaded turn gets whole seconds.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   clr   in  restart count at 0
//   tick  out one-cycle pulse once per TICK_CYCLES cycles
// -----------------------------------------------------------------------------
module memory_turn_ctrl_sec_tick #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick = (cnt_q == CNT_MAX);
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/memory_turn_ctrl.sv
// -----------------------------------------------------------------------------
// memory_turn_ctrl
// Game-rule FSM for the 16-card memory game. Accepts player card picks, drives
// the card bank's open/close/lock strobes, enforces a per-turn time limit,
// alternates players and keeps scores until all pairs are matched.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sel_valid, sel_idx       one-cycle card selection from the player
//   card_state, symbol_id    per-card state and symbol read from the bank
//   open_en/open_idx         pulse: turn one card face-up
//   close_pair_en/close_a/b  pulse: turn two cards face-down
//   lock_pair_en/lock_a/b    pulse: mark two cards matched
//   cur_player               player whose turn it is
//   score0, score1           pairs won per player
//   time_left                seconds left in the current turn
//   sel_err                  pulse: selection rejected
//   game_over                level: all pairs matched
// All outputs are registered; a selection accepted in cycle N shows its
// strobe in cycle N+1.
// -----------------------------------------------------------------------------
module memory_turn_ctrl
    import memory_turn_ctrl_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int TURN_SECS   = 15,
    parameter int SHOW_SECS   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sel_valid,
    input  logic [IDX_W-1:0]                  sel_idx,
    input  card_state_e [NUM_CARDS-1:0]       card_state,
    input  logic [NUM_CARDS-1:0][SYM_W-1:0]   symbol_id,
    output logic                              open_en,
    output logic [IDX_W-1:0]                  open_idx,
    output logic                              close_pair_en,
    output logic [IDX_W-1:0]                  close_a,
    output logic [IDX_W-1:0]                  close_b,
    output logic                              lock_pair_en,
    output logic [IDX_W-1:0]                  lock_a,
    output logic [IDX_W-1:0]                  lock_b,
    output logic                              cur_player,
    output logic [3:0]                        score0,
    output logic [3:0]                        score1,
    output logic [4:0]                        time_left,
    output logic                              sel_err,
    output logic                              game_over
);

    localparam logic [4:0] TURN_LD   = 5'(TURN_SECS);
    localparam logic [3:0] SCORE_MAX = 4'(NUM_PAIRS);
    localparam int         SHOW_W    = (SHOW_SECS > 1) ? $clog2(SHOW_SECS) : 1;
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_SECS - 1);

    turn_state_e       state_q, state_d;
    logic [IDX_W-1:0]  first_q, first_d, second_q, second_d;
    logic [3:0]        pairs_left_q, pairs_left_d;
    logic [SHOW_W-1:0] show_cnt_q, show_cnt_d;
    logic              open_en_q, open_en_d, close_pair_en_q, close_pair_en_d;
    logic              lock_pair_en_q, lock_pair_en_d, sel_err_q, sel_err_d;
    logic [IDX_W-1:0]  open_idx_q, open_idx_d, close_a_q, close_a_d, close_b_q, close_b_d;
    logic [IDX_W-1:0]  lock_a_q, lock_a_d, lock_b_q, lock_b_d;
    logic              cur_player_q, cur_player_d, game_over_q, game_over_d;
    logic [3:0]        score0_q, score0_d, score1_q, score1_d;
    logic [4:0]        time_left_q, time_left_d;

    logic tick;
    logic reload;     // restart the turn timer and the second counter
    logic timeout;
    logic pick_ok;

    memory_turn_ctrl_sec_tick #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (reload),
        .tick (tick)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        first_d         = first_q;
        second_d        = second_q;
        pairs_left_d    = pairs_left_q;
        show_cnt_d      = show_cnt_q;
        open_en_d       = 1'b0;
        close_pair_en_d = 1'b0;
        lock_pair_en_d  = 1'b0;
        sel_err_d       = 1'b0;
        open_idx_d      = open_idx_q;
        close_a_d       = close_a_q;
        close_b_d       = close_b_q;
        lock_a_d        = lock_a_q;
        lock_b_d        = lock_b_q;
        cur_player_d    = cur_player_q;
        game_over_d     = game_over_q;
        score0_d        = score0_q;
        score1_d        = score1_q;
        time_left_d     = time_left_q;
        reload          = 1'b0;

        timeout = tick && (time_left_q == 5'd1);
        // The bank only shows the first card face-up one cycle after open_en,
        // so re-picking the first card must be caught by index, not by state.
        pick_ok = (card_state[sel_idx] == CARD_DOWN) &&
                  ((state_q == T_PICK1) || (sel_idx != first_q));

        unique case (state_q)
            T_PICK1, T_PICK2: begin
                if (timeout) begin
                    // Timeout wins over a same-cycle selection, which is dropped.
                    if (state_q == T_PICK2) begin
                        close_pair_en_d = 1'b1;
                        close_a_d       = first_q;
                        close_b_d       = first_q;
                    end
                    cur_player_d = ~cur_player_q;
                    reload       = 1'b1;
                    state_d      = T_PICK1;
                end else begin
                    if (tick) begin
                        time_left_d = time_left_q - 5'd1;
                    end
                    if (sel_valid && pick_ok) begin
                        open_en_d  = 1'b1;
                        open_idx_d = sel_idx;
                        if (state_q == T_PICK1) begin
                            first_d = sel_idx;
                            state_d = T_PICK2;
                        end else begin
                            second_d   = sel_idx;
                            show_cnt_d = '0;
                            state_d    = T_SHOW;
                        end
                    end else if (sel_valid) begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            T_SHOW: begin
                if (tick) begin
                    if (show_cnt_q == SHOW_LAST) begin
                        show_cnt_d = '0;
                        state_d    = T_RESOLVE;
                    end else begin
                        show_cnt_d = show_cnt_q + 1'b1;
                    end
                end
            end
            T_RESOLVE: begin
                if (symbol_id[first_q] == symbol_id[second_q]) begin
                    lock_pair_en_d = 1'b1;
                    lock_a_d       = first_q;
                    lock_b_d       = second_q;
                    if (!cur_player_q && (score0_q != SCORE_MAX)) score0_d = score0_q + 4'd1;
                    if (cur_player_q && (score1_q != SCORE_MAX))  score1_d = score1_q + 4'd1;
                    pairs_left_d = pairs_left_q - 4'd1;
                    if (pairs_left_q == 4'd1) begin
                        game_over_d = 1'b1;
                        state_d     = T_OVER;
                    end else begin
                        reload  = 1'b1;
                        state_d = T_PICK1;
                    end
                end else begin
                    close_pair_en_d = 1'b1;
                    close_a_d       = first_q;
                    close_b_d       = second_q;
                    cur_player_d    = ~cur_player_q;
                    reload          = 1'b1;
                    state_d         = T_PICK1;
                end
            end
            T_OVER: begin
                // Terminal until reset; scores and timer hold.
            end
            default: state_d = T_PICK1;
        endcase

        if (reload) begin
            time_left_d = TURN_LD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= T_PICK1;
            first_q         <= '0;
            second_q        <= '0;
            pairs_left_q    <= 4'(NUM_PAIRS);
            show_cnt_q      <= '0;
            open_en_q       <= 1'b0;
            close_pair_en_q <= 1'b0;
            lock_pair_en_q  <= 1'b0;
            sel_err_q       <= 1'b0;
            open_idx_q      <= '0;
            close_a_q       <= '0;
            close_b_q       <= '0;
            lock_a_q        <= '0;
            lock_b_q        <= '0;
            cur_player_q    <= 1'b0;
            game_over_q     <= 1'b0;
            score0_q        <= '0;
            score1_q        <= '0;
            time_left_q     <= TURN_LD;
        end else begin
            state_q         <= state_d;
            first_q         <= first_d;
            second_q        <= second_d;
            pairs_left_q    <= pairs_left_d;
            show_cnt_q      <= show_cnt_d;
            open_en_q       <= open_en_d;
            close_pair_en_q <= close_pair_en_d;
            lock_pair_en_q  <= lock_pair_en_d;
            sel_err_q       <= sel_err_d;
            open_idx_q      <= open_idx_d;
            close_a_q       <= close_a_d;
            close_b_q       <= close_b_d;
            lock_a_q        <= lock_a_d;
            lock_b_q        <= lock_b_d;
            cur_player_q    <= cur_player_d;
            game_over_q     <= game_over_d;
            score0_q        <= score0_d;
            score1_q        <= score1_d;
            time_left_q     <= time_left_d;
        end
    end

    assign open_en       = open_en_q;
    assign open_idx      = open_idx_q;
    assign close_pair_en = close_pair_en_q;
    assign close_a       = close_a_q;
    assign close_b       = close_b_q;
    assign lock_pair_en  = lock_pair_en_q;
    assign lock_a        = lock_a_q;
    assign lock_b        = lock_b_q;
    assign cur_player    = cur_player_q;
    assign score0        = score0_q;
    assign score1        = score1_q;
    assign time_left     = time_left_q;
    assign sel_err       = sel_err_q;
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_memory_turn_ctrl
// Bench for memory_turn_ctrl with a small card bank (symbols 0,0,1,1,...),
// a game-level reference model checked every cycle, and directed turns with
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_memory_turn_ctrl;
    import memory_turn_ctrl_pkg::*;

    localparam int TICK = 4;
    localparam int TURN = 3;
    localparam int SHOW = 1;

    logic clk = 1'b0;
    logic rst;
    logic sel_valid;
    logic [3:0] sel_idx;
    card_state_e [NUM_CARDS-1:0] card_state;
    logic [NUM_CARDS-1:0][3:0] symbol_id;
    logic open_en, close_pair_en, lock_pair_en, cur_player, sel_err, game_over;
    logic [3:0] open_idx, close_a, close_b, lock_a, lock_b, score0, score1;
    logic [4:0] time_left;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    always #5 clk = ~clk;

    memory_turn_ctrl #(.TICK_CYCLES(TICK), .TURN_SECS(TURN), .SHOW_SECS(SHOW)) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .card_state(card_state), .symbol_id(symbol_id),
        .open_en(open_en), .open_idx(open_idx),
        .close_pair_en(close_pair_en), .close_a(close_a), .close_b(close_b),
        .lock_pair_en(lock_pair_en), .lock_a(lock_a), .lock_b(lock_b),
        .cur_player(cur_player), .score0(score0), .score1(score1),
        .time_left(time_left), .sel_err(sel_err), .game_over(game_over)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Card bank: reacts to the controller's strobes one cycle after they appear.
    initial for (int i = 0; i < NUM_CARDS; i++) symbol_id[i] = 4'(i / 2);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CARDS; i++) card_state[i] <= CARD_DOWN;
        end else begin
            if (open_en) card_state[open_idx] <= CARD_UP;
            if (close_pair_en) begin
                card_state[close_a] <= CARD_DOWN;
                card_state[close_b] <= CARD_DOWN;
            end
            if (lock_pair_en) begin
                card_state[lock_a] <= CARD_MATCH;
                card_state[lock_b] <= CARD_MATCH;
            end
        end
    end

    // ---------------- reference model (game level) ----------------
    localparam int M_FIRST = 0, M_SECOND = 1, M_SHOW = 2, M_RESOLVE = 3, M_DONE = 4;
    int m_phase, m_first, m_second, m_player, m_time, m_cyc, m_show_left;
    int m_score [2];
    card_state_e m_card [NUM_CARDS];
    bit e_open, e_close, e_lock, e_err, e_over;
    int e_oi, e_ca, e_cb, e_la, e_lb;

    always @(posedge clk) begin
        bit tk, n_open, n_close, n_lock, n_err;
        if (rst) begin
            m_phase = M_FIRST; m_player = 0; m_time = TURN; m_cyc = 0;
            m_score[0] = 0; m_score[1] = 0; m_first = 0; m_second = 0; m_show_left = 0;
            for (int i = 0; i < NUM_CARDS; i++) m_card[i] = CARD_DOWN;
            e_open = 0; e_close = 0; e_lock = 0; e_err = 0; e_over = 0;
            e_oi = 0; e_ca = 0; e_cb = 0; e_la = 0; e_lb = 0;
        end else begin
            // A second ticks in the last cycle of every TICK-cycle window
            // counted from reset or the latest turn reload.
            tk = (m_cyc % TICK) == TICK - 1;
            m_cyc++;
            n_open = 0; n_close = 0; n_lock = 0; n_err = 0;
            case (m_phase)
                M_FIRST, M_SECOND: begin
                    if (tk && m_time == 1) begin
                        if (m_phase == M_SECOND) begin n_close = 1; e_ca = m_first; e_cb = m_first; end
                        m_player = 1 - m_player; m_time = TURN; m_cyc = 0; m_phase = M_FIRST;
                    end else begin
                        if (tk) m_time--;
                        if (sel_valid) begin
                            if (m_card[sel_idx] == CARD_DOWN &&
                                !(m_phase == M_SECOND && int'(sel_idx) == m_first)) begin
                                n_open = 1; e_oi = int'(sel_idx);
                                if (m_phase == M_FIRST) begin
                                    m_first = int'(sel_idx); m_phase = M_SECOND;
                                end else begin
                                    m_second = int'(sel_idx); m_phase = M_SHOW; m_show_left = SHOW;
                                end
                            end else n_err = 1;
                        end
                    end
                end
                M_SHOW: if (tk) begin
                    m_show_left--;
                    if (m_show_left == 0) m_phase = M_RESOLVE;
                end
                M_RESOLVE: begin
                    if (symbol_id[m_first] == symbol_id[m_second]) begin
                        n_lock = 1; e_la = m_first; e_lb = m_second;
                        if (m_score[m_player] < NUM_PAIRS) m_score[m_player]++;
                        if (m_score[0] + m_score[1] == NUM_PAIRS) m_phase = M_DONE;
                        else begin m_phase = M_FIRST; m_time = TURN; m_cyc = 0; end
                    end else begin
                        n_close = 1; e_ca = m_first; e_cb = m_second;
                        m_player = 1 - m_player; m_phase = M_FIRST; m_time = TURN; m_cyc = 0;
                    end
                end
                default: ;
            endcase
            // Bank effect of the strobes visible during the cycle just ended.
            if (e_open) m_card[e_oi] = CARD_UP;
            if (e_close) begin m_card[e_ca] = CARD_DOWN; m_card[e_cb] = CARD_DOWN; end
            if (e_lock) begin m_card[e_la] = CARD_MATCH; m_card[e_lb] = CARD_MATCH; end
            e_open = n_open; e_close = n_close; e_lock = n_lock; e_err = n_err;
            e_over = (m_phase == M_DONE);
        end
        started = 1;
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            check("open_en", open_en, e_open);
            check("close_pair_en", close_pair_en, e_close);
            check("lock_pair_en", lock_pair_en, e_lock);
            check("sel_err", sel_err, e_err);
            check("cur_player", cur_player, m_player);
            check("score0", score0, m_score[0]);
            check("score1", score1, m_score[1]);
            check("time_left", time_left, m_time);
            check("game_over", game_over, e_over);
            if (e_open) check("open_idx", open_idx, e_oi);
            if (e_close) begin check("close_a", close_a, e_ca); check("close_b", close_b, e_cb); end
            if (e_lock) begin check("lock_a", lock_a, e_la); check("lock_b", lock_b, e_lb); end
        end
    end

    // ---------------- directed stimulus (called at a falling edge) ----------------
    task automatic pick(input int idx);
        sel_valid = 1'b1;
        sel_idx   = 4'(idx);
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic wait_strobe(input bit want_lock, input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = want_lock ? lock_pair_en : close_pair_en;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: strobe not seen within 40 cycles", name);
        end
    endtask

    task automatic play_match(input int a, input int b);
        pick(a);
        pick(b);
        wait_strobe(1'b1, "lock wait");
        check("lit lock_a", lock_a, a);
        check("lit lock_b", lock_b, b);
    endtask

    task automatic play_miss(input int a, input int b);
        pick(a);
        pick(b);
        wait_strobe(1'b0, "close wait");
        check("lit close_a", close_a, a);
        check("lit close_b", close_b, b);
        @(negedge clk);  // let the bank turn the cards back down
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " open_en"}, open_en, 0);
        check({tag, " close_pair_en"}, close_pair_en, 0);
        check({tag, " lock_pair_en"}, lock_pair_en, 0);
        check({tag, " sel_err"}, sel_err, 0);
        check({tag, " open_idx"}, open_idx, 0);
        check({tag, " close_a"}, close_a, 0);
        check({tag, " lock_b"}, lock_b, 0);
        check({tag, " cur_player"}, cur_player, 0);
        check({tag, " score0"}, score0, 0);
        check({tag, " score1"}, score1, 0);
        check({tag, " time_left"}, time_left, TURN);
        check({tag, " game_over"}, game_over, 0);
    endtask

    initial begin
        rst = 1'b1; sel_valid = 1'b0; sel_idx = 4'd0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Player 0 matches 0/1; open strobe lands the cycle after acceptance.
        pick(0);
        check("lit open_en first", open_en, 1);
        check("lit open_idx first", open_idx, 0);
        pick(1);
        check("lit open_idx second", open_idx, 1);
        wait_strobe(1'b1, "lock wait");
        check("lit lock_a 0", lock_a, 0);
        check("lit lock_b 1", lock_b, 1);
        check("lit score0 after match", score0, 1);
        check("lit player kept", cur_player, 0);
        check("lit time after match", time_left, 3);

        // Mismatch 2/4 hands the turn to player 1.
        play_miss(2, 4);
        check("lit player after miss", cur_player, 1);
        check("lit time after miss", time_left, 3);
        check("lit score0 unchanged", score0, 1);

        // Re-pick of the first card on the next cycle, then a matched card.
        pick(2);
        pick(2);
        check("lit reselect sel_err", sel_err, 1);
        check("lit reselect no open", open_en, 0);
        pick(0);
        check("lit matched sel_err", sel_err, 1);
        play_match(2, 3);
        check("lit score1 after match", score1, 1);

        // PICK2 timeout: pick 4 then idle; a pick on the timeout cycle is dropped.
        pick(4);
        repeat (10) @(negedge clk);
        check("lit time before timeout", time_left, 1);
        sel_valid = 1'b1; sel_idx = 4'd5;
        @(negedge clk);
        sel_valid = 1'b0;
        check("lit timeout close", close_pair_en, 1);
        check("lit timeout close_a", close_a, 4);
        check("lit timeout close_b", close_b, 4);
        check("lit timeout no sel_err", sel_err, 0);
        check("lit timeout no open", open_en, 0);
        check("lit timeout player", cur_player, 0);
        check("lit timeout reload", time_left, 3);

        // PICK1 timeout: idle a full turn.
        repeat (11) @(negedge clk);
        check("lit pick1 before timeout", cur_player, 0);
        @(negedge clk);
        check("lit pick1 timeout player", cur_player, 1);
        check("lit pick1 timeout reload", time_left, 3);

        // Finish the game: player 1 takes three more, player 0 takes three more.
        play_match(4, 5);
        play_match(6, 7);
        play_match(8, 9);
        play_miss(10, 12);
        play_match(10, 11);
        play_match(12, 13);
        play_match(14, 15);
        check("lit game_over", game_over, 1);
        check("lit final score0", score0, 4);
        check("lit final score1", score1, 4);
        pick(6);
        check("lit over no sel_err", sel_err, 0);
        check("lit over no open", open_en, 0);
        repeat (6) @(negedge clk);
        check("lit over holds", game_over, 1);

        // New game, then reset while both cards are showing.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pick(0);
        pick(2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("show reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        play_match(0, 1);
        check("lit score0 after restart", score0, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

endmodule
